// File: rtl/regfile_wr_arbiter_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
// Optional statistics are enabled by RFARB_STATS_EN (see regfile_wr_arbiter).
package regfile_pkg;

   typedef logic [4:0] reg_addr_t;

   typedef enum logic {
      INIT,
      ARB
   } state_t;

   localparam reg_addr_t REG_ZERO  = 5'd0;
   localparam int        RF_SIZE   = 32;
   localparam int        RF_DATA_N = 32;

endpackage

// File: rtl/regfile_wr_arbiter_if.sv
// Writeback request bus: requesters (master) offer valid/addr/data,
// the arbiter (slave) answers with a per-requester ready.
interface regfile_wr_arbiter_if #(
   parameter int NREQ   = 3,
   parameter int DATA_N = 32
) ();

   logic [NREQ-1:0]        req_valid_i;
   logic [NREQ-1:0]        req_ready_o;
   logic [NREQ*5-1:0]      req_addr_i;
   logic [NREQ*DATA_N-1:0] req_data_i;

   modport master (
      output req_valid_i,
      output req_addr_i,
      output req_data_i,
      input  req_ready_o
   );

   modport slave (
      input  req_valid_i,
      input  req_addr_i,
      input  req_data_i,
      output req_ready_o
   );

endinterface

// File: rtl/regfile_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester after ptr (wrapping)
// wins, so the last winner always has the lowest priority next time.
module rr_pick #(
   parameter  int NREQ  = 3,
   localparam int IDX_W = $clog2(NREQ)
) (
   input  logic [NREQ-1:0]  req,
   input  logic [IDX_W-1:0] ptr,
   output logic [NREQ-1:0]  gnt,
   output logic [IDX_W-1:0] idx,
   output logic             any
);

   logic [IDX_W-1:0] cand;

   always_comb begin
      gnt  = '0;
      idx  = '0;
      any  = 1'b0;
      cand = '0;
      for (int k = 1; k <= NREQ; k++) begin
         cand = IDX_W'((int'(ptr) + k) % NREQ);
         if (!any && req[cand]) begin
            any       = 1'b1;
            gnt[cand] = 1'b1;
            idx       = cand;
         end
      end
   end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Owns the register file write port: power-on sweep, then round-robin writeback.
// Define RFARB_STATS_EN to add the saturating conflict_cnt_o counter.
module regfile_wr_arbiter
   import regfile_pkg::*;
#(
   parameter  int                DATA_N   = RF_DATA_N,
   parameter  int                SIZE     = RF_SIZE,
   parameter  int                NREQ     = 3,
   parameter  int                INIT_IDX = 11,
   parameter  logic [DATA_N-1:0] INIT_VAL = DATA_N'(1),
   localparam int                IDX_W    = $clog2(NREQ)
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   regfile_wr_arbiter_if.slave  req_bus,
   output logic                 rd_wren_o,
   output reg_addr_t            rd_addr_o,
   output logic [DATA_N-1:0]    rd_data_o,
   output logic [IDX_W-1:0]     grant_id_o,
   output logic                 init_busy_o
`ifdef RFARB_STATS_EN
   ,
   output logic [15:0]          conflict_cnt_o
`endif
);

   localparam int CNT_W = $clog2(SIZE);

   state_t             state;
   state_t             next_state;
   logic [CNT_W-1:0]   sweep_cnt;
   logic [IDX_W-1:0]   rr_ptr;
   logic [NREQ-1:0]    pick_gnt;
   logic [IDX_W-1:0]   pick_idx;
   logic               pick_any;
   logic               sweep_last;
   reg_addr_t          addr_arr [NREQ];
   logic [DATA_N-1:0]  data_arr [NREQ];

   for (genvar g = 0; g < NREQ; g++) begin : g_unpack
      assign addr_arr[g] = req_bus.req_addr_i[5*g +: 5];
      assign data_arr[g] = req_bus.req_data_i[DATA_N*g +: DATA_N];
   end

   assign sweep_last = (sweep_cnt == CNT_W'(SIZE - 1));

   rr_pick #(.NREQ(NREQ)) u_pick (
      .req (req_bus.req_valid_i),
      .ptr (rr_ptr),
      .gnt (pick_gnt),
      .idx (pick_idx),
      .any (pick_any)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state <= INIT;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         INIT:    if (sweep_last) next_state = ARB;
         ARB:     next_state = ARB;
         default: next_state = INIT;
      endcase
   end

   // Requests are only acknowledged once the sweep is done; they stay pending meanwhile.
   always_comb begin
      init_busy_o         = (state == INIT);
      req_bus.req_ready_o = (state == ARB) ? pick_gnt : '0;
   end

   // Write-port registers; an accepted x0 write still updates addr/data but not wren.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sweep_cnt  <= '0;
         rr_ptr     <= IDX_W'(NREQ - 1);
         rd_wren_o  <= 1'b0;
         rd_addr_o  <= REG_ZERO;
         rd_data_o  <= '0;
         grant_id_o <= '0;
      end else if (state == INIT) begin
         rd_wren_o <= 1'b1;
         rd_addr_o <= reg_addr_t'(sweep_cnt);
         rd_data_o <= (sweep_cnt == CNT_W'(INIT_IDX)) ? INIT_VAL : '0;
         sweep_cnt <= sweep_last ? '0 : sweep_cnt + 1'b1;
      end else if (pick_any) begin
         rd_wren_o  <= (addr_arr[pick_idx] != REG_ZERO);
         rd_addr_o  <= addr_arr[pick_idx];
         rd_data_o  <= data_arr[pick_idx];
         grant_id_o <= pick_idx;
         rr_ptr     <= pick_idx;
      end else begin
         rd_wren_o <= 1'b0;
      end
   end

`ifdef RFARB_STATS_EN
   logic [15:0] conflict_cnt;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         conflict_cnt <= '0;
      end else if (state == ARB && $countones(req_bus.req_valid_i) >= 2
                   && conflict_cnt != 16'hFFFF) begin
         conflict_cnt <= conflict_cnt + 16'd1;
      end
   end

   assign conflict_cnt_o = conflict_cnt;
`endif

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed self-checking bench for regfile_wr_arbiter (sweep, round-robin,
// x0 suppression, mid-run reset; conflict counter when RFARB_STATS_EN is set).
module tb_regfile_wr_arbiter;
   import regfile_pkg::*;

   localparam int NREQ = 3;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   logic        rd_wren;
   reg_addr_t   rd_addr;
   logic [31:0] rd_data;
   logic [1:0]  grant_id;
   logic        init_busy;
`ifdef RFARB_STATS_EN
   logic [15:0] conflict_cnt;
`endif
   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   regfile_wr_arbiter_if #(.NREQ(NREQ), .DATA_N(32)) req_bus ();

   regfile_wr_arbiter dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .req_bus     (req_bus.slave),
      .rd_wren_o   (rd_wren),
      .rd_addr_o   (rd_addr),
      .rd_data_o   (rd_data),
      .grant_id_o  (grant_id),
      .init_busy_o (init_busy)
`ifdef RFARB_STATS_EN
      ,
      .conflict_cnt_o (conflict_cnt)
`endif
   );

   task automatic drive_idle();
      req_bus.req_valid_i = '0;
      req_bus.req_addr_i  = '0;
      req_bus.req_data_i  = '0;
   endtask

   task automatic drive_all_valid();
      req_bus.req_valid_i = 3'b111;
      req_bus.req_addr_i  = {5'd3, 5'd2, 5'd1};
      req_bus.req_data_i  = {32'h1111_0002, 32'h1111_0001, 32'h1111_0000};
   endtask

   task automatic test_reset();
      drive_all_valid();
      #12;
      checks++;
      if (rd_wren !== 1'b0 || rd_addr !== 5'd0 || rd_data !== 32'd0) begin
         errors++;
         $display("[TB] FAIL reset_write: wren=%b addr=%0d data=%h required 0/0/0", rd_wren, rd_addr, rd_data);
      end
      checks++;
      if (grant_id !== 2'd0 || init_busy !== 1'b1 || req_bus.req_ready_o !== 3'b000) begin
         errors++;
         $display("[TB] FAIL reset_ctrl: grant=%0d busy=%b ready=%b required 0/1/000", grant_id, init_busy, req_bus.req_ready_o);
      end
`ifdef RFARB_STATS_EN
      checks++;
      if (conflict_cnt !== 16'd0) begin
         errors++;
         $display("[TB] FAIL reset_conflict: got %0d required 0", conflict_cnt);
      end
`endif
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Valids stay high throughout; they are dropped once ARB is reached.
   task automatic test_init_sweep();
      logic [31:0] exp_data;
      for (int i = 0; i < 32; i++) begin
         @(negedge clk);
         exp_data = (i == 11) ? 32'd1 : 32'd0;
         checks++;
         if (rd_wren !== 1'b1 || rd_addr !== 5'(i) || rd_data !== exp_data) begin
            errors++;
            $display("[TB] FAIL sweep_write[%0d]: wren=%b addr=%0d data=%h required 1/%0d/%h", i, rd_wren, rd_addr, rd_data, i, exp_data);
         end
         checks++;
         if (init_busy !== (i < 31)) begin
            errors++;
            $display("[TB] FAIL sweep_busy[%0d]: got %b required %b", i, init_busy, (i < 31));
         end
         if (i < 31) begin
            checks++;
            if (req_bus.req_ready_o !== 3'b000) begin
               errors++;
               $display("[TB] FAIL sweep_ready[%0d]: got %b required 000", i, req_bus.req_ready_o);
            end
         end else begin
            checks++;
            if (req_bus.req_ready_o !== 3'b001) begin
               errors++;
               $display("[TB] FAIL first_arb_ready: got %b required 001", req_bus.req_ready_o);
            end
            drive_idle();
         end
      end
   endtask

   task automatic test_single();
      req_bus.req_valid_i = 3'b001;
      req_bus.req_addr_i  = {5'd0, 5'd0, 5'd5};
      req_bus.req_data_i  = {32'd0, 32'd0, 32'hDEADBEEF};
      #1;
      checks++;
      if (req_bus.req_ready_o !== 3'b001) begin
         errors++;
         $display("[TB] FAIL single_ready: got %b required 001", req_bus.req_ready_o);
      end
      @(negedge clk);
      checks++;
      if (rd_wren !== 1'b1 || rd_addr !== 5'd5 || rd_data !== 32'hDEADBEEF || grant_id !== 2'd0) begin
         errors++;
         $display("[TB] FAIL single_write: wren=%b addr=%0d data=%h grant=%0d required 1/5/deadbeef/0", rd_wren, rd_addr, rd_data, grant_id);
      end
      drive_idle();
      @(negedge clk);
      checks++;
      if (rd_wren !== 1'b0 || grant_id !== 2'd0) begin
         errors++;
         $display("[TB] FAIL idle_hold: wren=%b grant=%0d required 0/0", rd_wren, grant_id);
      end
   endtask

   // Last grant was 0, so rotation proceeds 1,2,0,1,2,0.
   task automatic test_back_to_back();
      int exp_order [6] = '{1, 2, 0, 1, 2, 0};
      drive_all_valid();
      for (int j = 0; j < 6; j++) begin
         #1;
         checks++;
         if (req_bus.req_ready_o !== (3'b001 << exp_order[j])) begin
            errors++;
            $display("[TB] FAIL b2b_ready[%0d]: got %b required %b", j, req_bus.req_ready_o, 3'b001 << exp_order[j]);
         end
         @(negedge clk);
         checks++;
         if (rd_wren !== 1'b1 || rd_addr !== 5'(exp_order[j] + 1) ||
             rd_data !== 32'h1111_0000 + 32'(exp_order[j]) || grant_id !== 2'(exp_order[j])) begin
            errors++;
            $display("[TB] FAIL b2b_write[%0d]: wren=%b addr=%0d data=%h grant=%0d required grant %0d", j, rd_wren, rd_addr, rd_data, grant_id, exp_order[j]);
         end
      end
      drive_idle();
   endtask

   task automatic test_x0_write();
      req_bus.req_valid_i = 3'b010;
      req_bus.req_addr_i  = {5'd0, 5'd0, 5'd0};
      req_bus.req_data_i  = {32'd0, 32'h55, 32'd0};
      #1;
      checks++;
      if (req_bus.req_ready_o !== 3'b010) begin
         errors++;
         $display("[TB] FAIL x0_ready: got %b required 010", req_bus.req_ready_o);
      end
      @(negedge clk);
      checks++;
      if (rd_wren !== 1'b0 || rd_addr !== 5'd0 || rd_data !== 32'h55 || grant_id !== 2'd1) begin
         errors++;
         $display("[TB] FAIL x0_write: wren=%b addr=%0d data=%h grant=%0d required 0/0/55/1", rd_wren, rd_addr, rd_data, grant_id);
      end
      req_bus.req_valid_i = 3'b110;
      req_bus.req_addr_i  = {5'd8, 5'd7, 5'd0};
      req_bus.req_data_i  = {32'h88, 32'h77, 32'd0};
      #1;
      checks++;
      if (req_bus.req_ready_o !== 3'b100) begin
         errors++;
         $display("[TB] FAIL x0_contention_ready: got %b required 100", req_bus.req_ready_o);
      end
      @(negedge clk);
      checks++;
      if (rd_wren !== 1'b1 || rd_addr !== 5'd8 || rd_data !== 32'h88 || grant_id !== 2'd2) begin
         errors++;
         $display("[TB] FAIL x0_contention_write: wren=%b addr=%0d data=%h grant=%0d required 1/8/88/2", rd_wren, rd_addr, rd_data, grant_id);
      end
      drive_idle();
   endtask

   task automatic test_reset_mid();
      req_bus.req_valid_i = 3'b001;
      req_bus.req_addr_i  = {5'd0, 5'd0, 5'd9};
      req_bus.req_data_i  = {32'd0, 32'd0, 32'hAA};
      @(posedge clk);
      #2;
      checks++;
      if (rd_wren !== 1'b1 || rd_addr !== 5'd9) begin
         errors++;
         $display("[TB] FAIL inflight_write: wren=%b addr=%0d required 1/9", rd_wren, rd_addr);
      end
      rst_n = 1'b0;
      drive_all_valid();
      #1;
      checks++;
      if (rd_wren !== 1'b0 || rd_addr !== 5'd0 || rd_data !== 32'd0 || grant_id !== 2'd0) begin
         errors++;
         $display("[TB] FAIL midreset_write: wren=%b addr=%0d data=%h grant=%0d required 0/0/0/0", rd_wren, rd_addr, rd_data, grant_id);
      end
      checks++;
      if (init_busy !== 1'b1 || req_bus.req_ready_o !== 3'b000) begin
         errors++;
         $display("[TB] FAIL midreset_ctrl: busy=%b ready=%b required 1/000", init_busy, req_bus.req_ready_o);
      end
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      test_init_sweep();
   endtask

`ifdef RFARB_STATS_EN
   task automatic test_stats();
      checks++;
      if (conflict_cnt !== 16'd0) begin
         errors++;
         $display("[TB] FAIL stats_start: got %0d required 0", conflict_cnt);
      end
      req_bus.req_valid_i = 3'b011;
      req_bus.req_addr_i  = {5'd14, 5'd13, 5'd12};
      req_bus.req_data_i  = {32'h3, 32'h2, 32'h1};
      repeat (4) @(negedge clk);
      req_bus.req_valid_i = 3'b100;
      repeat (3) @(negedge clk);
      drive_idle();
      checks++;
      if (conflict_cnt !== 16'd4) begin
         errors++;
         $display("[TB] FAIL stats_count: got %0d required 4", conflict_cnt);
      end
   endtask
`endif

   initial begin
      drive_idle();
      test_reset();
      test_init_sweep();
      test_single();
      test_back_to_back();
      test_x0_write();
      test_reset_mid();
`ifdef RFARB_STATS_EN
      test_stats();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
